axis_pkt_arbiter_4: RTL and testbench

Packet-aware round-robin arbiter that drives the `sel` input of the 4:1 AXI-stream mux. It shares one downstream stream between four upstream requesters and holds each grant from the first beat to the `last` beat of a packet. It monitors per-port valid/last and downstream ready, and emits a registered, glitch-free select plus a qualifying grant flag. An optional watchdog bounds packet length.

---
 rtl/axis_arb_pkg.sv | 38 +++
 rtl/rr_pick_4.sv | 22 ++
 rtl/axis_pkt_arbiter_4.sv | 135 +++++++++++++
 tb/tb_axis_pkt_arbiter_4.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_arb_pkg
// Description : Shared types, constants and the rotate-priority search used by
//               the packet-aware AXI-stream arbiter family.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

    localparam int NUM_PORTS = 4;
    localparam int SEL_W     = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Round-robin search: first requester at or after ptr, wrapping at the top.
    // Scanning from the farthest offset down lets the nearest hit overwrite.
    // With no requester the result is ptr; callers qualify it with |req.
    function automatic logic [SEL_W-1:0] rr_next(
        input logic [SEL_W-1:0]     ptr,
        input logic [NUM_PORTS-1:0] req
    );
        logic [SEL_W-1:0] win;
        logic [SEL_W-1:0] idx;
        win = ptr;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_4
// Description : Combinational 4-way rotate-priority picker. Returns the first
//               requester at or after ptr (wrapping 3 -> 0) and whether any
//               requester is present.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_4
    import axis_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic [SEL_W-1:0]     win,
    output logic                 any
);

    assign any = |req;
    assign win = rr_next(ptr, req);

endmodule
`default_nettype wire

// File: rtl/axis_pkt_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_arbiter_4
// Description : Packet-aware round-robin arbiter driving the select of a 4:1
//               AXI-stream mux. A grant is held from the first beat until the
//               last beat of a packet is accepted; sel/gnt are registered.
//               Optional watchdog (macro AXIS_ARB_WDOG_EN) forces release on
//               the MAX_BEATS-th beat of a packet and pulses pkt_err.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_arbiter_4
    import axis_arb_pkg::*;
#(
    parameter int MAX_BEATS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 valid_0,
    input  logic                 valid_1,
    input  logic                 valid_2,
    input  logic                 valid_3,
    input  logic                 last_0,
    input  logic                 last_1,
    input  logic                 last_2,
    input  logic                 last_3,
    input  logic                 ready,
    output logic [SEL_W-1:0]     sel,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 grant_valid,
    output logic                 pkt_err
);

    arb_state_t             r_state;
    logic [SEL_W-1:0]       r_ptr;

    logic [NUM_PORTS-1:0]   w_valid;
    logic [NUM_PORTS-1:0]   w_last;
    logic                   w_xfer;
    logic                   w_eop;
    logic                   w_wdog;
    logic                   w_release;
    logic [SEL_W-1:0]       w_pick_ptr;
    logic [SEL_W-1:0]       w_win;
    logic                   w_any;

    assign w_valid   = {valid_3, valid_2, valid_1, valid_0};
    assign w_last    = {last_3, last_2, last_1, last_0};
    assign w_xfer    = grant_valid & w_valid[sel] & ready;
    assign w_eop     = w_xfer & w_last[sel];
    assign w_release = w_eop | w_wdog;

    // On release the search starts just past the current owner, so the owner
    // only wins again when it is the sole requester in that cycle.
    assign w_pick_ptr = (r_state == ST_BUSY) ? (sel + 2'd1) : r_ptr;

    rr_pick_4 u_pick (
        .req (w_valid),
        .ptr (w_pick_ptr),
        .win (w_win),
        .any (w_any)
    );

    // Grant FSM: arbitrate in IDLE, hold sel through the packet, re-arbitrate
    // with zero bubble on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            sel         <= '0;
            gnt         <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_any) begin
                        sel         <= w_win;
                        gnt         <= 4'b0001 << w_win;
                        grant_valid <= 1'b1;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
                        r_ptr <= sel + 2'd1;
                        if (enable && w_any) begin
                            sel <= w_win;
                            gnt <= 4'b0001 << w_win;
                        end else begin
                            gnt         <= '0;
                            grant_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    gnt         <= '0;
                    grant_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AXIS_ARB_WDOG_EN
    localparam int c_cnt_w = $clog2(MAX_BEATS + 1);
    localparam logic [c_cnt_w-1:0] c_beat_limit = c_cnt_w'(MAX_BEATS - 1);

    logic [c_cnt_w-1:0] r_beats;

    // The MAX_BEATS-th accepted beat of a packet that is not last is treated
    // as end of packet.
    assign w_wdog = w_xfer & ~w_last[sel] & (r_beats == c_beat_limit);

    // Beat counter and one-cycle error pulse for watchdog releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beats <= '0;
            pkt_err <= 1'b0;
        end else begin
            pkt_err <= w_wdog;
            if (w_release) begin
                r_beats <= '0;
            end else if (w_xfer) begin
                r_beats <= r_beats + c_cnt_w'(1);
            end
        end
    end
`else
    assign w_wdog  = 1'b0;
    assign pkt_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pkt_arbiter_4
// Description : Self-checking bench for axis_pkt_arbiter_4: a vector table,
//               directed multi-cycle sequences and randomized traffic checked
//               against a behavioural owner/priority model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_arbiter_4;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] v = '0;
    logic [3:0] l = '0;
    logic       ready = 1'b0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       grant_valid;
    logic       pkt_err;

    int total = 0;
    int bad   = 0;

    // Reference model state: who owns the stream (-1 = nobody), where the next
    // search starts, last granted port, beats of current packet, error pulse.
    int m_owner;
    int m_sel;
    int m_start;
    int m_beats;
    bit m_err;

    typedef struct {
        bit         rst_before;
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        logic       e;
        logic [1:0] sel;
        logic       gv;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    axis_pkt_arbiter_4 #(.MAX_BEATS(MAXB)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .valid_0     (v[0]),
        .valid_1     (v[1]),
        .valid_2     (v[2]),
        .valid_3     (v[3]),
        .last_0      (l[0]),
        .last_1      (l[1]),
        .last_2      (l[2]),
        .last_3      (l[3]),
        .ready       (ready),
        .sel         (sel),
        .gnt         (gnt),
        .grant_valid (grant_valid),
        .pkt_err     (pkt_err)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_scan(input int start, input logic [3:0] req);
        for (int k = 0; k < 4; k++) begin
            if (req[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_start = 0;
        m_beats = 0;
        m_err   = 1'b0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit xfer;
        bit done;
        bit wd;
        int w;
        xfer = (m_owner >= 0) && v[m_owner] && ready;
        done = xfer && l[m_owner];
        wd   = 1'b0;
`ifdef AXIS_ARB_WDOG_EN
        if (xfer && !done && (m_beats + 1 == MAXB)) wd = 1'b1;
`endif
        if (done || wd) m_beats = 0;
        else if (xfer)  m_beats = m_beats + 1;
        m_err = wd;
        if (m_owner < 0) begin
            if (enable) begin
                w = rr_scan(m_start, v);
                if (w >= 0) begin
                    m_owner = w;
                    m_sel   = w;
                end
            end
        end else if (done || wd) begin
            m_start = (m_owner + 1) % 4;
            w = enable ? rr_scan(m_start, v) : -1;
            m_owner = w;
            if (w >= 0) m_sel = w;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v = '0; l = '0; ready = 1'b0; enable = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic drive(input logic [3:0] vv, input logic [3:0] ll,
                         input logic rr, input logic ee);
        @(negedge clk);
        v = vv; l = ll; ready = rr; enable = ee;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_exp(input string tag, input int esel, input bit egv, input bit eerr);
        check({tag, ".sel"}, int'(sel), esel);
        check({tag, ".gv"},  int'(grant_valid), int'(egv));
        check({tag, ".gnt"}, int'(gnt), egv ? (1 << esel) : 0);
        check({tag, ".err"}, int'(pkt_err), int'(eerr));
    endtask

    task automatic step_exp(input string tag, input logic [3:0] vv, input logic [3:0] ll,
                            input logic rr, input logic ee,
                            input int esel, input bit egv, input bit eerr);
        drive(vv, ll, rr, ee);
        check_exp(tag, esel, egv, eerr);
    endtask

    task automatic add_vec(input bit rb, input logic [3:0] vv, input logic [3:0] ll,
                           input logic rr, input logic ee, input logic [1:0] es, input logic eg);
        vec_t t;
        t.rst_before = rb; t.v = vv; t.l = ll; t.r = rr; t.e = ee; t.sel = es; t.gv = eg;
        tbl.push_back(t);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;

        // Reset state
        check_exp("reset", 0, 1'b0, 1'b0);

        // Fairness: all four valid, 2-beat packets (last high on 2nd beat)
        add_vec(1, 4'hF, 4'h0, 1, 1, 2'd0, 1);
        add_vec(0, 4'hF, 4'h0, 1, 1, 2'd0, 1);
        add_vec(0, 4'hF, 4'hF, 1, 1, 2'd1, 1);
        add_vec(0, 4'hF, 4'h0, 1, 1, 2'd1, 1);
        add_vec(0, 4'hF, 4'hF, 1, 1, 2'd2, 1);
        add_vec(0, 4'hF, 4'h0, 1, 1, 2'd2, 1);
        add_vec(0, 4'hF, 4'hF, 1, 1, 2'd3, 1);
        add_vec(0, 4'hF, 4'h0, 1, 1, 2'd3, 1);
        add_vec(0, 4'hF, 4'hF, 1, 1, 2'd0, 1);
        // Backpressure on port 1 while port 3 waits
        add_vec(1, 4'b0010, 4'b0000, 1, 1, 2'd1, 1);
        add_vec(0, 4'b0010, 4'b0000, 1, 1, 2'd1, 1);
        add_vec(0, 4'b1010, 4'b0000, 0, 1, 2'd1, 1);
        add_vec(0, 4'b1010, 4'b0010, 0, 1, 2'd1, 1);
        add_vec(0, 4'b1010, 4'b0010, 1, 1, 2'd3, 1);
        add_vec(0, 4'b1000, 4'b0000, 1, 1, 2'd3, 1);
        // Port 3 sole requester at its eop: granted again
        add_vec(0, 4'b1000, 4'b1000, 1, 1, 2'd3, 1);
        add_vec(0, 4'b0000, 4'b0000, 1, 1, 2'd3, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            step_exp($sformatf("vec%0d", i), tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].e,
                     int'(tbl[i].sel), tbl[i].gv, 1'b0);
        end

        // Single requester, 3-beat packet on port 2
        do_reset();
        step_exp("single.arb",  4'b0100, 4'b0000, 1, 1, 2, 1, 0);
        step_exp("single.b1",   4'b0100, 4'b0000, 1, 1, 2, 1, 0);
        step_exp("single.b2",   4'b0100, 4'b0000, 1, 1, 2, 1, 0);
        step_exp("single.b3",   4'b0100, 4'b0100, 1, 1, 2, 1, 0);
        step_exp("single.hold", 4'b0000, 4'b0000, 1, 1, 2, 1, 0);
        step_exp("single.eop",  4'b0100, 4'b0100, 1, 0, 2, 0, 0);
        step_exp("single.idle", 4'b0000, 4'b0000, 1, 1, 2, 0, 0);

        // Enable dropped during port 0's packet
        do_reset();
        step_exp("en.arb",  4'b0001, 4'b0000, 1, 1, 0, 1, 0);
        step_exp("en.b1",   4'b0111, 4'b0000, 1, 0, 0, 1, 0);
        step_exp("en.eop",  4'b0111, 4'b0001, 1, 0, 0, 0, 0);
        step_exp("en.off1", 4'b0110, 4'b0000, 1, 0, 0, 0, 0);
        step_exp("en.off2", 4'b0110, 4'b0000, 1, 0, 0, 0, 0);
        step_exp("en.on",   4'b0110, 4'b0000, 1, 1, 1, 1, 0);

        // Watchdog: port 0 streams without last, port 1 waiting
        do_reset();
        step_exp("wd.arb", 4'b0001, 4'b0000, 1, 1, 0, 1, 0);
        step_exp("wd.b1",  4'b0011, 4'b0000, 1, 1, 0, 1, 0);
        step_exp("wd.b2",  4'b0011, 4'b0000, 1, 1, 0, 1, 0);
        step_exp("wd.b3",  4'b0011, 4'b0000, 1, 1, 0, 1, 0);
`ifdef AXIS_ARB_WDOG_EN
        step_exp("wd.b4",  4'b0011, 4'b0000, 1, 1, 1, 1, 1);
        step_exp("wd.b5",  4'b0011, 4'b0000, 1, 1, 1, 1, 0);
`else
        step_exp("wd.b4",  4'b0011, 4'b0000, 1, 1, 0, 1, 0);
        step_exp("wd.b5",  4'b0011, 4'b0000, 1, 1, 0, 1, 0);
`endif

        // Asynchronous reset between clock edges, mid-packet on port 2
        do_reset();
        step_exp("ar.arb", 4'b0100, 4'b0000, 1, 1, 2, 1, 0);
        step_exp("ar.b1",  4'b0100, 4'b0000, 1, 1, 2, 1, 0);
        @(negedge clk);
        #2;
        rst = 1'b1; v = '0; l = '0;
        model_reset();
        #1;
        check_exp("ar.async", 0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step_exp("ar.after", 4'b1111, 4'b0000, 1, 1, 0, 1, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [3:0] rv;
            logic [3:0] rl;
            rv = 4'($urandom_range(0, 15));
            rl = 4'($urandom) & 4'($urandom);
            drive(rv, rl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));
            check_exp($sformatf("rnd%0d", i), m_sel, (m_owner >= 0), m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
